tsp: RTL and testbench



---
 rtl/tsp.sv | 141 ++++++++++++++
 tb/tb_tsp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsp.sv
// Travelling-salesman demo: generates 64 xorshift32 points, then builds a greedy nearest-neighbour tour from point 0.
// Latency: done rises 4160 cycles after reset release (64 GEN + 1 INIT + 63 x (64 SCAN + 1 COMMIT)).
// Backpressure: none; free-running after reset, all outputs hold once done until the next reset.
module tsp #(
    parameter logic [31:0] SEED = 32'd2463534242
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] xs   [64],
    output logic [7:0] ys   [64],
    output logic [5:0] path [64],
    output logic       done
);

    typedef enum logic [2:0] {
        GEN    = 3'd0,
        INIT   = 3'd1,
        SCAN   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t       state_q;
    logic [31:0]  prng_q;
    logic [5:0]   idx_q;
    logic [63:0]  visited_q;
    logic [5:0]   cur_q;
    logic [5:0]   step_q;
    logic [5:0]   j_q;
    logic [5:0]   best_q;
    logic [16:0]  best_d_q;
    logic         done_q;
    logic [7:0]   xs_q   [64];
    logic [7:0]   ys_q   [64];
    logic [5:0]   path_q [64];

    logic [31:0]  prng_d;
    logic [7:0]   dx_d;
    logic [7:0]   dy_d;
    logic [15:0]  sqx_d;
    logic [15:0]  sqy_d;
    logic [16:0]  dist_d;

    // xorshift32 step from the current PRNG state
    always_comb begin
        prng_d = prng_q;
        prng_d = prng_d ^ (prng_d << 13);
        prng_d = prng_d ^ (prng_d >> 17);
        prng_d = prng_d ^ (prng_d << 5);
    end

    // Squared distance between the current tour head and candidate j (one shared multiplier pair)
    always_comb begin
        dx_d   = (xs_q[cur_q] >= xs_q[j_q]) ? (xs_q[cur_q] - xs_q[j_q]) : (xs_q[j_q] - xs_q[cur_q]);
        dy_d   = (ys_q[cur_q] >= ys_q[j_q]) ? (ys_q[cur_q] - ys_q[j_q]) : (ys_q[j_q] - ys_q[cur_q]);
        sqx_d  = 16'(dx_d) * 16'(dx_d);
        sqy_d  = 16'(dy_d) * 16'(dy_d);
        dist_d = 17'(sqx_d) + 17'(sqy_d);
    end

    // Main sequencer: point generation, then repeated scan/commit of the nearest unvisited point
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GEN;
            prng_q    <= SEED;
            idx_q     <= '0;
            visited_q <= '0;
            cur_q     <= '0;
            step_q    <= '0;
            j_q       <= '0;
            best_q    <= '0;
            best_d_q  <= '1;
            done_q    <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                xs_q[i]   <= '0;
                ys_q[i]   <= '0;
                path_q[i] <= '0;
            end
        end else begin
            case (state_q)
                GEN: begin
                    prng_q       <= prng_d;
                    xs_q[idx_q]  <= prng_d[31:24];
                    ys_q[idx_q]  <= prng_d[15:8];
                    idx_q        <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    path_q[0] <= '0;
                    visited_q <= 64'd1;
                    cur_q     <= '0;
                    step_q    <= 6'd1;
                    j_q       <= '0;
                    best_q    <= '0;
                    best_d_q  <= '1;
                    state_q   <= SCAN;
                end
                SCAN: begin
                    // strict less-than keeps the lowest index on ties
                    if (!visited_q[j_q] && (dist_d < best_d_q)) begin
                        best_d_q <= dist_d;
                        best_q   <= j_q;
                    end
                    j_q <= j_q + 6'd1;
                    if (j_q == 6'd63) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    path_q[step_q]    <= best_q;
                    visited_q[best_q] <= 1'b1;
                    cur_q             <= best_q;
                    step_q            <= step_q + 6'd1;
                    best_d_q          <= '1;
                    j_q               <= '0;
                    if (step_q == 6'd63) begin
                        // done rises on the same edge that commits the last point
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= GEN;
                end
            endcase
        end
    end

    assign xs   = xs_q;
    assign ys   = ys_q;
    assign path = path_q;
    assign done = done_q;

endmodule

// File: tb/tb_tsp.sv
// Bench for tsp: reference model of point generation and greedy tour, scoreboard queue checked when done rises.
// Also checks reset behaviour, GEN start timing, exact latency, output stability and a SEED=1 instance.
// Mid-run reset point is randomised inside the scan phase.
module tb_tsp;

    localparam logic [31:0] DSEED = 32'd2463534242;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] xs   [64];
    logic [7:0] ys   [64];
    logic [5:0] path [64];
    logic       done;
    logic [7:0] xs1   [64];
    logic [7:0] ys1   [64];
    logic [5:0] path1 [64];
    logic       done1;

    always #5 clk = ~clk;

    tsp #(.SEED(DSEED)) dut (.clk(clk), .rst(rst), .xs(xs), .ys(ys), .path(path), .done(done));
    tsp #(.SEED(32'd1)) dut1 (.clk(clk), .rst(rst), .xs(xs1), .ys(ys1), .path(path1), .done(done1));

    int errors = 0;
    int checks = 0;

    typedef struct {
        int tag;   // 0 = path, 1 = xs, 2 = ys
        int idx;
        int val;
    } exp_t;
    exp_t sbq[$];

    int ex [64];
    int ey [64];
    int ep [64];
    int mon_hits = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: generate points from the seed, then nearest-neighbour tour over plain arrays
    task automatic build_model(input logic [31:0] seed);
        logic [31:0] s;
        bit          vis [64];
        int          cur, bj, bd, d, dx, dy;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            ex[i] = int'(s[31:24]);
            ey[i] = int'(s[15:8]);
        end
        for (int i = 0; i < 64; i++) vis[i] = 1'b0;
        ep[0] = 0;
        vis[0] = 1'b1;
        cur = 0;
        for (int k = 1; k < 64; k++) begin
            bd = 1 << 30;
            bj = -1;
            for (int j = 0; j < 64; j++) begin
                dx = ex[cur] - ex[j];
                dy = ey[cur] - ey[j];
                d  = dx * dx + dy * dy;
                if (!vis[j] && d < bd) begin
                    bd = d;
                    bj = j;
                end
            end
            ep[k] = bj;
            vis[bj] = 1'b1;
            cur = bj;
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < 64; i++) begin
            sbq.push_back('{0, i, ep[i]});
            sbq.push_back('{1, i, ex[i]});
            sbq.push_back('{2, i, ey[i]});
        end
    endtask

    task automatic check_zero(input string name);
        int nzx, nzy, nzp;
        nzx = 0; nzy = 0; nzp = 0;
        for (int i = 0; i < 64; i++) begin
            if (xs[i] != 0) nzx++;
            if (ys[i] != 0) nzy++;
            if (path[i] != 0) nzp++;
        end
        chk({name, "_xs_nonzero"}, nzx, 0);
        chk({name, "_ys_nonzero"}, nzy, 0);
        chk({name, "_path_nonzero"}, nzp, 0);
        chk({name, "_done"}, done, 0);
    endtask

    task automatic check_vs_model(input string name);
        int bx, by, bp;
        bit seen [64];
        int dup;
        bx = 0; by = 0; bp = 0; dup = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (int'(xs[i]) != ex[i]) bx++;
            if (int'(ys[i]) != ey[i]) by++;
            if (int'(path[i]) != ep[i]) bp++;
            if (seen[path[i]]) dup++;
            seen[path[i]] = 1'b1;
        end
        chk({name, "_xs_diffs"}, bx, 0);
        chk({name, "_ys_diffs"}, by, 0);
        chk({name, "_path_diffs"}, bp, 0);
        chk({name, "_path_dups"}, dup, 0);
        chk({name, "_path0"}, path[0], 0);
        chk({name, "_done"}, done, 1);
    endtask

    // Monitor: when done rises, drain the scoreboard against the presented outputs
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            exp_t e;
            int   act;
            mon_hits++;
            chk("mon_queue_nonempty", (sbq.size() > 0), 1);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.tag)
                    0:       act = int'(path[e.idx]);
                    1:       act = int'(xs[e.idx]);
                    default: act = int'(ys[e.idx]);
                endcase
                checks++;
                if (act != e.val) begin
                    errors++;
                    $display("FAIL sb_%s[%0d]: got %0d, expected %0d",
                             (e.tag == 0) ? "path" : ((e.tag == 1) ? "xs" : "ys"), e.idx, act, e.val);
                end
            end
        end
        done_prev = done;
    end

    initial begin
        int n;
        int rst_at;
        int nz;
        rst = 1'b1;
        build_model(DSEED);

        // Held reset: outputs stay cleared
        for (int i = 0; i < 10; i++) begin
            tick();
            check_zero("hold_rst");
        end
        rst = 1'b0;

        // GEN starts on the first edge after release
        tick();
        n = 1;
        chk("gen_first_xs0", xs[0], ex[0]);
        chk("gen_first_ys0", ys[0], ey[0]);
        chk("gen_first_xs1_unwritten", xs[1], 0);
        chk("gen_first_done", done, 0);

        while (n < 64) begin
            tick();
            n++;
        end
        chk("seed1_xs0", xs1[0], 8'h00);
        chk("seed1_ys0", ys1[0], 8'h20);
        chk("seed1_xs1", xs1[1], 8'h04);
        chk("seed1_ys1", ys1[1], 8'h06);
        chk("gen_end_xs63", xs[63], ex[63]);
        chk("gen_end_ys63", ys[63], ey[63]);

        while (n < 1000) begin
            tick();
            n++;
        end
        nz = 0;
        for (int i = 0; i < 64; i++) if (xs[i] != 0 && ys[i] != 0) nz++;
        chk("spread_nonzero_ge32", (nz >= 32), 1);
        chk("c1000_path0", path[0], 0);
        chk("c1000_xs17", xs[17], ex[17]);

        // Mid-scan reset, one cycle
        rst_at = $urandom_range(2100, 1900);
        while (n < rst_at) begin
            tick();
            n++;
        end
        chk("pre_rst_done", done, 0);
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;

        // Full run: expected tour goes to the scoreboard, latency counted in edges
        push_expected();
        n = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
            if (n == 4159) chk("done_low_at_4159", done, 0);
        end
        chk("latency_edges", n, 4160);
        check_vs_model("at_done");

        while (n < 20000) begin
            tick();
            n++;
        end
        check_vs_model("c20000");
        chk("monitor_fired", mon_hits, 1);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
